// File: rtl/bg_line_fetcher_if.sv
// SDRAM read port between the background line fetcher (master) and the arbiter (slave).
// The master holds the address and read strobe; the slave returns the data with an accept pulse.
interface bg_line_fetcher_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport master (output mem_addr, output mem_rd, input mem_ack, input mem_data);
    modport slave  (input mem_addr, input mem_rd, output mem_ack, output mem_data);
endinterface

// File: rtl/bg_line_fetcher.sv
// Background scanline prefetcher: fetches framebuffer row y+1 into one half of a
// ping-pong line buffer while line y is served as palette indices from the other half.
module bg_line_fetcher #(
    parameter int              H_ACTIVE   = 640,
    parameter int              H_TOTAL    = 800,
    parameter int              V_ACTIVE   = 480,
    parameter int              V_TOTAL    = 525,
    parameter int              LINE_WORDS = 320,
    parameter int              FB_ROWS    = 480,
    parameter int              ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] BASE0    = 25'h09CD20,
    parameter logic [ADDR_W-1:0] BASE1    = 25'h0C2520,
    localparam int             X_W        = $clog2(H_TOTAL),
    localparam int             Y_W        = $clog2(V_TOTAL)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [X_W-1:0]     draw_x,
    input  logic [Y_W-1:0]     draw_y,
    input  logic               blank,
    input  logic               new_frame,
    input  logic               swap_req,
    input  logic [8:0]         scroll_x,
    input  logic [8:0]         scroll_y,
    bg_line_fetcher_if.master  mem,
    output logic               busy,
    output logic               frame_sel,
    output logic [7:0]         pix_index,
    output logic               pix_valid,
    output logic               underrun
);
    localparam int W_W = $clog2(LINE_WORDS);
    localparam int B_W = $clog2(2 * LINE_WORDS);
    localparam logic [W_W-1:0] LAST_W = W_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t            r_state;
    logic [X_W-1:0]    r_prev_x;
    logic [W_W-1:0]    r_w;
    logic [W_W-1:0]    r_col;
    logic              r_half;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_busy;
    logic              r_frame_sel;
    logic              r_swap_pend;
    logic              r_underrun;
    logic              r_pix_valid;
    logic [7:0]        r_pix_index;
    logic [15:0]       r_buf [0:2*LINE_WORDS-1];

    logic [Y_W-1:0]    w_t;
    logic              w_trig;
    logic              w_swap;
    logic              w_fsel_nxt;
    logic              w_wr;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_src_row;
    logic [ADDR_W-1:0] w_line_base;
    logic [W_W-1:0]    w_col0;
    logic [W_W-1:0]    w_col_nxt;
    logic [X_W-1:0]    w_x_word;
    logic [B_W-1:0]    w_wr_idx;
    logic [B_W-1:0]    w_rd_idx;
    logic [15:0]       w_rd_word;

    assign w_t    = (draw_y == Y_W'(V_TOTAL - 1)) ? Y_W'(0) : draw_y + Y_W'(1);
    assign w_trig = (draw_x == X_W'(0)) && (r_prev_x != X_W'(0)) && (w_t < Y_W'(V_ACTIVE));

    // The fetch started on the new_frame cycle already belongs to the newly selected buffer.
    assign w_swap      = new_frame && (r_swap_pend || swap_req);
    assign w_fsel_nxt  = r_frame_sel ^ w_swap;
    assign w_src_row   = (ADDR_W'(w_t) + ADDR_W'(scroll_y)) % ADDR_W'(FB_ROWS);
    assign w_line_base = (w_fsel_nxt ? BASE1 : BASE0) + w_src_row * ADDR_W'(LINE_WORDS);
    assign w_col0      = W_W'(ADDR_W'(scroll_x) % ADDR_W'(LINE_WORDS));
    assign w_col_nxt   = (r_col == LAST_W) ? W_W'(0) : r_col + W_W'(1);

    assign w_wr      = (r_state == REQ) && mem.mem_ack && !reset;
    assign w_wr_idx  = r_half ? B_W'(LINE_WORDS) + B_W'(r_w) : B_W'(r_w);
    assign w_x_word  = {1'b0, draw_x[X_W-1:1]};
    assign w_rd_ok   = (draw_x < X_W'(H_ACTIVE)) && (w_x_word < X_W'(LINE_WORDS));
    assign w_rd_idx  = w_rd_ok ? ((draw_y[0] ? B_W'(LINE_WORDS) : B_W'(0)) + B_W'(w_x_word)) : B_W'(0);
    assign w_rd_word = r_buf[w_rd_idx];

    // Line buffer write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_buf[w_wr_idx] <= mem.mem_data;
        end
    end

    // Fetch FSM, frame-select bookkeeping and registered pixel output
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prev_x    <= {X_W{1'b1}};
            r_w         <= W_W'(0);
            r_col       <= W_W'(0);
            r_half      <= 1'b0;
            r_line_base <= ADDR_W'(0);
            r_mem_addr  <= ADDR_W'(0);
            r_mem_rd    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_sel <= 1'b0;
            r_swap_pend <= 1'b0;
            r_underrun  <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_index <= 8'd0;
        end else begin
            r_prev_x    <= draw_x;
            r_frame_sel <= w_fsel_nxt;
            if (w_swap) begin
                r_swap_pend <= 1'b0;
            end else if (swap_req) begin
                r_swap_pend <= 1'b1;
            end
            r_pix_valid <= blank;
            r_pix_index <= blank ? (draw_x[0] ? w_rd_word[7:0] : w_rd_word[15:8]) : 8'd0;

            if (w_trig) begin
                if (r_state != IDLE) begin
                    r_underrun <= 1'b1;
                end
                r_state     <= REQ;
                r_mem_rd    <= 1'b1;
                r_busy      <= 1'b1;
                r_w         <= W_W'(0);
                r_col       <= w_col0;
                r_half      <= w_t[0];
                r_line_base <= w_line_base;
                r_mem_addr  <= w_line_base + ADDR_W'(w_col0);
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    REQ: begin
                        if (mem.mem_ack) begin
                            if (r_w == LAST_W) begin
                                r_state  <= DONE;
                                r_mem_rd <= 1'b0;
                                r_busy   <= 1'b0;
                            end else begin
                                r_w        <= r_w + W_W'(1);
                                r_col      <= w_col_nxt;
                                r_mem_addr <= r_line_base + ADDR_W'(w_col_nxt);
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_rd   = r_mem_rd;
    assign busy         = r_busy;
    assign frame_sel    = r_frame_sel;
    assign pix_index    = r_pix_index;
    assign pix_valid    = r_pix_valid;
    assign underrun     = r_underrun;
endmodule

// File: tb/tb_bg_line_fetcher.sv
// Directed bench for bg_line_fetcher: a line-level model of fetch addresses, buffer
// contents, frame swap and underrun is checked against the DUT every cycle.
module tb_bg_line_fetcher;
    localparam logic [24:0] BASE0 = 25'h09CD20;
    localparam logic [24:0] BASE1 = 25'h0C2520;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] draw_x, draw_y;
    logic       blank, new_frame, swap_req;
    logic [8:0] scroll_x, scroll_y;
    logic       busy, frame_sel, pix_valid, underrun;
    logic [7:0] pix_index;
    logic       ack_en;
    logic       cmp_en = 1'b0;

    int total = 0;
    int bad   = 0;

    bg_line_fetcher_if #(.ADDR_W(25)) mem_if ();

    bg_line_fetcher dut (
        .clock(clock), .reset(reset), .draw_x(draw_x), .draw_y(draw_y), .blank(blank),
        .new_frame(new_frame), .swap_req(swap_req), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .mem(mem_if), .busy(busy), .frame_sel(frame_sel), .pix_index(pix_index),
        .pix_valid(pix_valid), .underrun(underrun)
    );

    always #5 clock = ~clock;

    // SDRAM contents: an address hash, plus one marker word at row 2, word 5 of buffer 0
    function automatic logic [15:0] mem_fn(input logic [24:0] a);
        return (a == 25'h09CFA5) ? 16'hA1B2 : (a[15:0] ^ 16'h3C5A);
    endfunction

    assign mem_if.mem_data = mem_fn(mem_if.mem_addr);
    assign mem_if.mem_ack  = ack_en & mem_if.mem_rd;

    // model state
    bit          m_active, m_done, m_fsel, m_pend, m_under, m_pv, m_pix_known;
    logic [7:0]  m_pix;
    int          m_w, m_half, m_px;
    logic [24:0] m_list [0:319];
    logic [15:0] m_buf  [0:639];
    bit          m_known[0:639];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int t, row, idx;
        logic [24:0] base;
        logic [15:0] word;
        bit was_busy, trig;
        if (reset) begin
            m_active = 0; m_done = 0; m_fsel = 0; m_pend = 0; m_under = 0;
            m_pv = 0; m_pix = 8'h00; m_pix_known = 1; m_px = -1;
            return;
        end
        m_pv = blank;
        if (!blank) begin
            m_pix = 8'h00; m_pix_known = 1;
        end else if (int'(draw_x) / 2 < 320) begin
            idx = (int'(draw_y) % 2) * 320 + int'(draw_x) / 2;
            word = m_buf[idx];
            m_pix_known = m_known[idx];
            m_pix = (int'(draw_x) % 2 == 1) ? word[7:0] : word[15:8];
        end else begin
            m_pix_known = 0;
        end
        if (new_frame && (m_pend || swap_req)) begin
            m_fsel = !m_fsel; m_pend = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
        was_busy = m_active || m_done;
        m_done = 0;
        if (m_active && ack_en) begin
            idx = m_half * 320 + m_w;
            m_buf[idx] = mem_fn(m_list[m_w]);
            m_known[idx] = 1;
            m_w++;
            if (m_w == 320) begin
                m_active = 0; m_done = 1;
            end
        end
        t = (int'(draw_y) == 524) ? 0 : int'(draw_y) + 1;
        trig = (draw_x == 10'd0) && (m_px != 0) && (t < 480);
        if (trig) begin
            if (was_busy) m_under = 1;
            row  = (t + int'(scroll_y)) % 480;
            base = m_fsel ? BASE1 : BASE0;
            for (int w = 0; w < 320; w++)
                m_list[w] = base + 25'(row * 320 + (w + int'(scroll_x)) % 320);
            m_active = 1; m_done = 0; m_w = 0; m_half = t % 2;
        end
        m_px = int'(draw_x);
    endtask

    task automatic step(input int x, input int y);
        draw_x = 10'(x);
        draw_y = 10'(y);
        blank  = (x < 320) && (y < 480);
        @(posedge clock);
        model_update();
        #1;
        new_frame = 1'b0;
        swap_req  = 1'b0;
    endtask

    task automatic run_line(input int y, input int x0);
        for (int x = x0; x < 400; x++) step(x, y);
    endtask

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("mem_rd", 32'(mem_if.mem_rd), 32'(m_active));
            chk("busy", 32'(busy), 32'(m_active));
            if (m_active) chk("mem_addr", 32'(mem_if.mem_addr), 32'(m_list[m_w]));
            chk("frame_sel", 32'(frame_sel), 32'(m_fsel));
            chk("underrun", 32'(underrun), 32'(m_under));
            chk("pix_valid", 32'(pix_valid), 32'(m_pv));
            if (m_pix_known) chk("pix_index", 32'(pix_index), 32'(m_pix));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_len;
        logic [24:0] last_addr;
        reset = 1'b1; ack_en = 1'b1; new_frame = 1'b0; swap_req = 1'b0;
        scroll_x = 9'd0; scroll_y = 9'd0; draw_x = 10'd5; draw_y = 10'd0; blank = 1'b0;
        repeat (3) step(5, 0);
        cmp_en = 1'b1;
        chk("rst_mem_rd", 32'(mem_if.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_sel", 32'(frame_sel), 32'd0);
        chk("rst_pix_index", 32'(pix_index), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;

        // line 0 fetches row 1, one ack per cycle
        new_frame = 1'b1;
        step(0, 0);
        chk("t1_first_addr", 32'(mem_if.mem_addr), 32'h0009CE60);
        busy_len = 0; last_addr = 25'd0;
        for (int x = 1; x < 400; x++) begin
            if (busy) busy_len++;
            if (mem_if.mem_rd) last_addr = mem_if.mem_addr;
            step(x, 0);
        end
        chk("t1_last_addr", 32'(last_addr), 32'h0009CF9F);
        chk("t1_busy_within_322", 32'(busy_len >= 320 && busy_len <= 322), 32'd1);

        // row 2 lands in half 0 and is displayed on line 2
        run_line(1, 0);
        for (int x = 0; x < 400; x++) begin
            step(x, 2);
            if (x == 10) begin
                chk("pix_x10", 32'(pix_index), 32'h000000A1);
                chk("pix_x10_valid", 32'(pix_valid), 32'd1);
            end
            if (x == 11) chk("pix_x11", 32'(pix_index), 32'h000000B2);
            if (x == 350) begin
                chk("pix_blank_valid", 32'(pix_valid), 32'd0);
                chk("pix_blank_index", 32'(pix_index), 32'd0);
            end
        end

        // scroll wrap on both axes; a mid-line scroll change must not disturb the fetch
        scroll_x = 9'd319; scroll_y = 9'd479;
        step(0, 0);
        chk("scroll_first_addr", 32'(mem_if.mem_addr), 32'h0009CE5F);
        step(1, 0);
        chk("scroll_second_addr", 32'(mem_if.mem_addr), 32'h0009CD20);
        scroll_x = 9'd7; scroll_y = 9'd3;
        run_line(0, 2);
        scroll_x = 9'd0; scroll_y = 9'd0;

        // swap request mid-frame takes effect on the next new_frame only
        for (int x = 0; x < 400; x++) begin
            if (x == 50) swap_req = 1'b1;
            step(x, 5);
        end
        chk("swap_not_midframe", 32'(frame_sel), 32'd0);
        new_frame = 1'b1;
        step(0, 0);
        chk("swap_at_new_frame", 32'(frame_sel), 32'd1);
        chk("swap_base1_addr", 32'(mem_if.mem_addr), 32'h000C2660);
        run_line(0, 1);
        step(0, 524);
        chk("last_line_target0", 32'(mem_if.mem_addr), 32'h000C2520);
        run_line(524, 1);
        new_frame = 1'b1;
        step(0, 0);
        chk("no_swap_keeps_sel", 32'(frame_sel), 32'd1);
        run_line(0, 1);

        // starved fetch: next trigger flags underrun and restarts on the new row
        ack_en = 1'b0;
        run_line(3, 0);
        chk("underrun_before", 32'(underrun), 32'd0);
        step(0, 4);
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_restart_addr", 32'(mem_if.mem_addr), 32'h000C2B60);
        ack_en = 1'b1;
        run_line(4, 1);
        chk("underrun_sticky", 32'(underrun), 32'd1);

        // reset while 100 words into a fetch
        for (int x = 0; x <= 100; x++) step(x, 6);
        chk("mid_fetch_addr_w100", 32'(mem_if.mem_addr), 32'h000C2E44);
        reset = 1'b1;
        step(101, 6);
        reset = 1'b0;
        chk("reset_mid_rd", 32'(mem_if.mem_rd), 32'd0);
        chk("reset_mid_busy", 32'(busy), 32'd0);
        chk("reset_mid_underrun", 32'(underrun), 32'd0);
        run_line(6, 102);
        step(0, 7);
        chk("after_reset_first_addr", 32'(mem_if.mem_addr), 32'h0009D720);
        run_line(7, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bg_line_fetcher.md
Name: bg_line_fetcher

Overview:
- Parametrised background scanline prefetcher for the VGA path.
- While line y is displayed, it fetches framebuffer row y+1 from SDRAM into one half of a ping-pong line buffer. It serves palette indices for line y from the other half.
- Adds over the previous background mapper: double-buffered frame base with vblank-synchronised swap, X/Y scroll with wrap-around, and a sticky underrun flag.
- Sits between the SDRAM arbiter and the palette ROM / colour mapper.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- LINE_WORDS, 320, 16-bit words per framebuffer row (two 8-bit indices per word)
- FB_ROWS, 480, rows stored per framebuffer
- ADDR_W, 25, SDRAM word-address width
- BASE0, 25'h09CD20, word address of framebuffer 0
- BASE1, 25'h0C2520, word address of framebuffer 1

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- draw_x  in  10  current VGA column
- draw_y  in  10  current VGA line
- blank  in  1  1 = active display region
- new_frame  in  1  single-cycle pulse at start of each frame
- swap_req  in  1  single-cycle pulse requesting a framebuffer swap
- scroll_x  in  9  horizontal scroll, in words
- scroll_y  in  9  vertical scroll, in rows
- mem_addr  out  ADDR_W  read word address
- mem_rd  out  1  read request
- mem_ack  in  1  read accepted; mem_data valid this cycle
- mem_data  in  16  read data
- busy  out  1  fetch in progress
- frame_sel  out  1  framebuffer currently displayed (0 → BASE0, 1 → BASE1)
- pix_index  out  8  palette index for the pixel
- pix_valid  out  1  pix_index meaningful
- underrun  out  1  sticky: a fetch missed its deadline

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, busy=0, frame_sel=0, pix_index=0, pix_valid=0, underrun=0; swap-pending flag=0; FSM=IDLE; word counter=0.
- Target line t = (draw_y==V_TOTAL-1) ? 0 : draw_y+1.
- Fetch trigger: cycle where draw_x==0, the column is sampled on a new value, and t<V_ACTIVE. Exactly one trigger per line.
- Write half = t[0]. Read half = draw_y[0]. The two halves never collide.
- Scroll values are latched at the trigger and held for the whole line:
  - src_row = (t + scroll_y) mod FB_ROWS
  - col(w) = (w + scroll_x) mod LINE_WORDS, for w = 0..LINE_WORDS-1
  - mem_addr = base + src_row*LINE_WORDS + col(w), where base = frame_sel ? BASE1 : BASE0
  - All arithmetic is ADDR_W wide with no truncation before the final sum.
- FSM states and transitions:
  - IDLE → REQ on trigger.
  - REQ: mem_rd=1, busy=1, mem_addr stable until mem_ack.
    - On mem_ack, write mem_data to buffer[write half][w].
    - If w==LINE_WORDS-1 → DONE; otherwise w+1, stay in REQ.
    - mem_rd stays high across back-to-back acks. One outstanding read at a time.
  - DONE: busy=0 for one cycle, then → IDLE.
- Underrun: a trigger arriving while FSM≠IDLE
  - sets underrun=1 (cleared only by reset);
  - aborts the current fetch;
  - restarts at w=0 for the new target on the next cycle.
  - A mem_ack coincident with the trigger is written before the abort.
- Frame swap:
  - swap_req sets swap-pending.
  - On new_frame with pending set: frame_sel toggles and pending clears, in the same cycle.
  - swap_req and new_frame in the same cycle: toggle happens on this new_frame.
  - frame_sel never changes mid-frame.
- Pixel output, 1-cycle latency:
  - Word read from buffer[draw_y[0]][draw_x>>1].
  - pix_index = draw_x[0] ? word[7:0] : word[15:8].
  - pix_valid = registered blank. pix_index=0 whenever the registered blank is 0.
- Reset mid-fetch: mem_rd=0 on the cycle after reset is sampled. Partial line contents are not cleared.
- Buffer: 2×LINE_WORDS×16, inferred dual-port RAM, read-during-write to the other half only.

Test Plan:
- Reset, then new_frame and line timing with mem_ack every cycle, scroll 0, frame_sel 0:
  - fetch for t=1 (at draw_y=0) issues addresses 0x09CD20+320 .. +639;
  - busy drops within 322 cycles.
- Buffer half 0 preloaded with word 0xA1B2 at index 5, draw_y=2, draw_x=10 then 11 → pix_index 0xA1, then 0xB2, each one cycle later; pix_valid follows blank.
- scroll_x=319, scroll_y=479, t=1 →
  - first address = BASE0 + 0*320 + 319;
  - second address = BASE0 + 0;
  - (wrap in both axes).
- swap_req mid-frame, then new_frame → frame_sel 0→1 exactly at new_frame; next fetch uses BASE1. A second new_frame without swap_req leaves frame_sel=1.
- mem_ack held low for a whole line → at next draw_x==0, underrun=1, fetch restarts at w=0 with the new target row; underrun stays 1.
- Reset asserted during REQ with w=100 → mem_rd=0, busy=0, FSM=IDLE next cycle; the following trigger fetches from w=0.
